// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_sched_ctrl (plus helper g_function)
// Brief    : Iterative AES-128 key schedule. Expands one round key per cycle
//            into an 11 x 128-bit store, then streams the round keys forward
//            or in reverse over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================

// AES key-schedule g function: SubWord(RotWord(w)) ^ {rcon, 24'h0}
module g_function (
  input  logic [31:0] word_in,
  input  logic [7:0]  rcon_in,
  output logic [31:0] word_out
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (a^254, with 0 -> 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] rot_word;

  // Rotate, substitute each byte, fold in the round constant
  always_comb begin
    rot_word = {word_in[23:0], word_in[31:24]};
    word_out = {sbox(rot_word[31:24]) ^ rcon_in, sbox(rot_word[23:16]),
                sbox(rot_word[15:8]), sbox(rot_word[7:0])};
  end

endmodule

module aes_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_ready,
  input  logic         rk_start,
  input  logic         rk_dir,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         rk_last
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_READY  = 2'd2,
    S_STREAM = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   work_q, work_d;        // previous round key, so the store is write-only while expanding
  logic [3:0]     r_q, r_d;
  logic [7:0]     rcon_q, rcon_d;
  logic           keys_ready_q, keys_ready_d;
  logic [3:0]     idx_q, idx_d;
  logic           dir_q, dir_d;
  logic           rk_valid_q, rk_valid_d;

  logic [127:0]   store_q [0:10];
  logic           store_we;
  logic [3:0]     store_waddr;
  logic [127:0]   store_wdata;

  logic [31:0]    g_out;
  logic [127:0]   next_key;
  logic           accept;
  logic           xfer;

  g_function u_g (
    .word_in  (work_q[31:0]),
    .rcon_in  (rcon_q),
    .word_out (g_out)
  );

  // Next round key from the working register, plus output decode
  always_comb begin
    next_key[127:96] = g_out ^ work_q[127:96];
    next_key[95:64]  = next_key[127:96] ^ work_q[95:64];
    next_key[63:32]  = next_key[95:64]  ^ work_q[63:32];
    next_key[31:0]   = next_key[63:32]  ^ work_q[31:0];

    key_ready  = (state_q == S_IDLE) || (state_q == S_READY);
    busy       = (state_q == S_EXPAND);
    keys_ready = keys_ready_q;
    rk_valid   = rk_valid_q;
    rk_index   = idx_q;
    rk_last    = rk_valid_q && (dir_q ? (idx_q == 4'd0) : (idx_q == 4'd10));
    rk_data    = rk_valid_q ? store_q[idx_q] : 128'h0;
    accept     = key_valid && key_ready;
    xfer       = rk_valid_q && rk_ready;
  end

  // Next-state logic; a key load takes priority over a stream request
  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    r_d          = r_q;
    rcon_d       = rcon_q;
    keys_ready_d = keys_ready_q;
    idx_d        = idx_q;
    dir_d        = dir_q;
    rk_valid_d   = rk_valid_q;
    store_we     = 1'b0;
    store_waddr  = 4'd0;
    store_wdata  = key_in;

    case (state_q)
      S_IDLE, S_READY: begin
        if (accept) begin
          store_we     = 1'b1;
          store_waddr  = 4'd0;
          store_wdata  = key_in;
          work_d       = key_in;
          r_d          = 4'd1;
          rcon_d       = 8'h01;
          keys_ready_d = 1'b0;
          state_d      = S_EXPAND;
        end else if (state_q == S_READY && rk_start) begin
          idx_d      = rk_dir ? 4'd10 : 4'd0;
          dir_d      = rk_dir;
          rk_valid_d = 1'b1;
          state_d    = S_STREAM;
        end
      end
      S_EXPAND: begin
        store_we    = 1'b1;
        store_waddr = r_q;
        store_wdata = next_key;
        work_d      = next_key;
        rcon_d      = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (r_q == 4'd10) begin
          keys_ready_d = 1'b1;
          state_d      = S_READY;
        end else begin
          r_d = r_q + 4'd1;
        end
      end
      S_STREAM: begin
        if (xfer) begin
          if (rk_last) begin
            rk_valid_d = 1'b0;
            state_d    = S_READY;
          end else begin
            idx_d = dir_q ? (idx_q - 4'd1) : (idx_q + 4'd1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and working registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      work_q       <= 128'h0;
      r_q          <= 4'd0;
      rcon_q       <= 8'h01;
      keys_ready_q <= 1'b0;
      idx_q        <= 4'd0;
      dir_q        <= 1'b0;
      rk_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      work_q       <= work_d;
      r_q          <= r_d;
      rcon_q       <= rcon_d;
      keys_ready_q <= keys_ready_d;
      idx_q        <= idx_d;
      dir_q        <= dir_d;
      rk_valid_q   <= rk_valid_d;
    end
  end

  // Single-write-port round-key store; contents survive reset, keys_ready guards them
  always_ff @(posedge clk) begin
    if (rst_n && store_we) begin
      store_q[store_waddr] <= store_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_sched_ctrl
// Brief    : Directed self-checking bench for the AES-128 key-schedule controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         keys_ready;
  logic         rk_start;
  logic         rk_dir;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         rk_last;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;

  aes_key_sched_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .busy       (busy),
    .keys_ready (keys_ready),
    .rk_start   (rk_start),
    .rk_dir     (rk_dir),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_data    (rk_data),
    .rk_index   (rk_index),
    .rk_last    (rk_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_keys(output int n);
    n = 0;
    while (!keys_ready && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".key_ready"},  key_ready,  1'b1);
    chk({tag, ".busy"},       busy,       1'b0);
    chk({tag, ".keys_ready"}, keys_ready, 1'b0);
    chk({tag, ".rk_valid"},   rk_valid,   1'b0);
    chk({tag, ".rk_last"},    rk_last,    1'b0);
    chk({tag, ".rk_index"},   rk_index,   4'd0);
    chk({tag, ".rk_data"},    rk_data,    128'h0);
  endtask

  initial begin
    int           n;
    int           stall;
    logic [127:0] held_data;

    rst_n = 1'b0; key_in = '0; key_valid = 1'b0;
    rk_start = 1'b0; rk_dir = 1'b0; rk_ready = 1'b0;

    // Reset
    tick(); tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // rk_start in IDLE is ignored
    rk_start = 1'b1;
    tick();
    chk("idle_start.rk_valid", rk_valid, 1'b0);
    rk_start = 1'b0;

    // Load FIPS key; hold rk_start during EXPAND (ignored)
    key_in = FIPS_KEY; key_valid = 1'b1;
    tick();
    key_valid = 1'b0; rk_start = 1'b1;
    chk("load.busy", busy, 1'b1);
    chk("load.key_ready", key_ready, 1'b0);
    chk("load.keys_ready", keys_ready, 1'b0);
    wait_keys(n);
    rk_start = 1'b0;
    chk("fips.latency", n, 10);
    chk("fips.busy_done", busy, 1'b0);
    chk("fips.key_ready", key_ready, 1'b1);
    chk("expand_start.rk_valid", rk_valid, 1'b0);

    // Forward stream, rk_ready held; key_valid/rk_start offered during STREAM
    rk_dir = 1'b0; rk_start = 1'b1;
    tick();
    rk_start = 1'b1; key_valid = 1'b1; key_in = 128'h0; rk_ready = 1'b1;
    chk("fwd.rk_valid", rk_valid, 1'b1);
    for (int i = 0; i <= 10; i++) begin
      chk($sformatf("fwd.index%0d", i), rk_index, i[3:0]);
      chk($sformatf("fwd.data%0d", i), rk_data, FIPS_RK[i]);
      chk($sformatf("fwd.last%0d", i), rk_last, (i == 10));
      chk($sformatf("fwd.key_ready%0d", i), key_ready, 1'b0);
      if (i == 10) begin
        key_valid = 1'b0; rk_start = 1'b0;
      end
      tick();
    end
    rk_ready = 1'b0;
    chk("fwd.end_valid", rk_valid, 1'b0);
    chk("fwd.end_data", rk_data, 128'h0);
    chk("fwd.keys_ready", keys_ready, 1'b1);

    // Reverse stream
    rk_dir = 1'b1; rk_start = 1'b1;
    tick();
    rk_start = 1'b0; rk_ready = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      chk($sformatf("rev.index%0d", i), rk_index, i[3:0]);
      chk($sformatf("rev.data%0d", i), rk_data, FIPS_RK[i]);
      chk($sformatf("rev.last%0d", i), rk_last, (i == 0));
      tick();
    end
    rk_ready = 1'b0;
    chk("rev.end_valid", rk_valid, 1'b0);

    // key_valid and rk_start together in READY: load wins
    key_in = 128'h0; key_valid = 1'b1; rk_dir = 1'b0; rk_start = 1'b1;
    tick();
    key_valid = 1'b0; rk_start = 1'b0;
    chk("prio.rk_valid", rk_valid, 1'b0);
    chk("prio.keys_ready", keys_ready, 1'b0);
    chk("prio.busy", busy, 1'b1);
    wait_keys(n);
    chk("zero.latency", n, 10);

    // All-zero key, forward stream with random stalls
    rk_start = 1'b1;
    tick();
    rk_start = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      held_data = rk_data;
      stall = $urandom_range(0, 5);
      rk_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        tick();
        chk($sformatf("stall.valid%0d", i), rk_valid, 1'b1);
        chk($sformatf("stall.index%0d", i), rk_index, i[3:0]);
        chk($sformatf("stall.data%0d", i), rk_data, held_data);
        chk($sformatf("stall.last%0d", i), rk_last, (i == 10));
      end
      rk_ready = 1'b1;
      chk($sformatf("zero.index%0d", i), rk_index, i[3:0]);
      chk($sformatf("zero.last%0d", i), rk_last, (i == 10));
      if (i == 0) chk("zero.rk0", rk_data, 128'h0);
      if (i == 1) chk("zero.rk1", rk_data, ZERO_RK1);
      tick();
    end
    rk_ready = 1'b0;
    chk("zero.count_end", rk_valid, 1'b0);

    // Reset at expansion cycle 5 aborts, then a fresh load completes correctly
    key_in = FIPS_KEY; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (4) tick();
    chk("abort.busy_before", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    chk_reset_outputs("abort");
    rst_n = 1'b1;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    wait_keys(n);
    chk("reload.latency", n, 10);
    rk_dir = 1'b1; rk_start = 1'b1;
    tick();
    rk_start = 1'b0;
    chk("reload.index", rk_index, 4'd10);
    chk("reload.rk10", rk_data, FIPS_RK[10]);
    rk_ready = 1'b1;
    repeat (11) tick();
    rk_ready = 1'b0;
    chk("reload.end_valid", rk_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Sequential AES-128 key-schedule controller. It accepts a 128-bit cipher key over a valid/ready handshake and expands it iteratively, one round key per cycle, into an internal 11 x 128-bit round-key store. It then streams the round keys to an iterative cipher core over a second valid/ready handshake, in forward order (rk0..rk10, encryption) or reverse order (rk10..rk0, decryption). It replaces the fully unrolled combinational expansion wherever area matters, and reuses the existing `g_function` block (32-bit word, 8-bit rcon in; 32-bit word out) once.

## Interface
Parameters: none; the key length is fixed at 128 bits and the schedule at 11 round keys.

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- key_in  in  128  cipher key; word w0 = key_in[127:96]
- key_valid  in  1  key_in is offered
- key_ready  out  1  controller can accept a key; high in IDLE and READY
- busy  out  1  high while in EXPAND
- keys_ready  out  1  the store holds a complete, valid schedule
- rk_start  in  1  request a round-key stream; sampled only in READY
- rk_dir  in  1  0 = forward (rk0 first), 1 = reverse (rk10 first); sampled with rk_start
- rk_valid  out  1  rk_data/rk_index are valid
- rk_ready  in  1  consumer accepts the current round key
- rk_data  out  128  current round key, {w[4i], w[4i+1], w[4i+2], w[4i+3]}
- rk_index  out  4  index i of rk_data, 0..10
- rk_last  out  1  high with the final key of a stream (rk10 forward, rk0 reverse)

## Operation
- States: IDLE (no valid schedule), EXPAND, READY, STREAM.
- Key load:
  - A key is accepted on an edge where key_valid && key_ready.
  - On acceptance: slot0 <= key_in, round counter r <= 1, rcon <= 8'h01, keys_ready <= 0, state <= EXPAND.
- EXPAND, one cycle per r = 1..10:
  - t = g_function(prev.w3, rcon).
  - Next key: w0' = t ^ prev.w0, w1' = w0' ^ prev.w1, w2' = w1' ^ prev.w2, w3' = w2' ^ prev.w3.
  - The new key is written to slot r.
  - rcon advances by GF(2^8) xtime: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
  - Writing r = 10 sets state <= READY and keys_ready <= 1.
- Previous-key source: held in a dedicated 128-bit working register, so the store has only a single write port and is never read during expansion.
- READY:
  - key_valid && key_ready has priority: a new load starts and rk_start is ignored in that cycle.
  - Otherwise, rk_start: idx <= (rk_dir ? 10 : 0), rk_valid <= 1, state <= STREAM.
- STREAM:
  - rk_data = slot[idx], rk_index = idx.
  - On an rk_valid && rk_ready edge: idx steps by +1 (forward) or -1 (reverse).
  - The transfer with rk_last set returns the block to READY with rk_valid <= 0.
  - key_ready = 0 and rk_start is ignored in STREAM.
- rk_start is also ignored in IDLE and EXPAND; it is not queued.
- key_valid is ignored while key_ready = 0; the offering side must hold it.

## Timing
- Reset (rst_n = 0 at an edge): state IDLE, keys_ready 0, busy 0, rk_valid 0, rk_last 0, rk_index 0, rk_data 0, key_ready 1, r 0, rcon 8'h01. Store contents are not cleared; keys_ready guards them.
- A reset mid-EXPAND or mid-STREAM aborts immediately. The next schedule needs a fresh key load.
- Expansion latency:
  - The key is accepted at edge E0; slots 1..10 are written at edges E1..E10.
  - busy is high after E0 through E10; keys_ready rises after E10.
  - Exactly 10 cycles from acceptance to keys_ready.
- Stream:
  - rk_valid rises the cycle after rk_start is sampled.
  - With rk_ready held high, 11 keys transfer on 11 consecutive edges.
  - rk_data, rk_index and rk_last stay stable while rk_valid && !rk_ready (arbitrary stall length).
- rk_data is 0 whenever rk_valid = 0.
- A back-to-back key load is accepted on the same edge that READY is entered+1; there is no extra dead cycle.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, forward stream with rk_ready = 1:
  - keys_ready exactly 10 cycles after acceptance.
  - rk1 = a0fafe1788542cb123a339392a6c7605.
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with rk_last on index 10.
- Same key, rk_dir = 1: first transfer is rk_index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; rk_last on index 0 with data 2b7e151628aed2a6abf7158809cf4f3c.
- All-zero key, random rk_ready stalls of 0-5 cycles:
  - rk1 = 62636363626363636263636362636363.
  - Outputs stable during every stall.
  - Exactly 11 transfers.
- key_valid and rk_start high in the same READY cycle: the key is loaded, no stream starts, rk_valid stays 0, and keys_ready drops the next cycle.
- rst_n = 0 at expansion cycle 5: all outputs take their reset values; a subsequent load of the FIPS key gives the correct rk10.
- rk_start in IDLE, EXPAND and STREAM, and key_valid in STREAM: all ignored; key_ready = 0 throughout STREAM.
